// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: streams one cache block from 16-bit main memory into the
// data array on a miss, and forwards write-through stores to memory while idle.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected_i,
    input  logic [ADDR_WIDTH-1:0]              miss_address_i,
    input  logic                               wr_req_i,
    input  logic [ADDR_WIDTH-1:0]              wr_addr_i,
    input  logic [15:0]                        wr_data_i,
    input  logic [15:0]                        memory_data_i,
    output logic                               fsm_busy_o,
    output logic                               write_data_array_o,
    output logic                               write_tag_array_o,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_o,
    output logic [15:0]                        fill_data_o,
    output logic [ADDR_WIDTH-1:0]              fill_base_o,
    output logic                               mem_en_o,
    output logic                               mem_wr_o,
    output logic [ADDR_WIDTH-1:0]              memory_address_o,
    output logic [15:0]                        mem_data_in_o,
    output logic                               wr_ack_o
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   fill_base_q, fill_base_d;
    logic [ADDR_WIDTH-1:0]   word_off_s;
    logic                    last_word_s;
    logic                    unused_s;

    // Store byte lane select is not meaningful on a 16-bit memory.
    assign unused_s    = wr_addr_i[0];
    assign word_off_s  = ADDR_WIDTH'({cnt_q, 1'b0});
    assign last_word_s = (cnt_q == LAST_CNT);
    assign fill_base_o = fill_base_q;

    // State, word counter and latched block base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            fill_base_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_base_q <= fill_base_d;
        end
    end

    // Next-state logic; a miss is only accepted from IDLE so a held request cannot re-trigger mid-fill.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_base_d = fill_base_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_detected_i) begin
                    state_d     = ST_FILL;
                    cnt_d       = {CNT_W{1'b0}};
                    fill_base_d = miss_address_i & BLK_MASK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (last_word_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Memory port and array strobes; the block is aligned so base+offset never carries out of it.
    always_comb begin
        fsm_busy_o         = 1'b0;
        write_data_array_o = 1'b0;
        write_tag_array_o  = 1'b0;
        fill_word_o        = {CNT_W{1'b0}};
        fill_data_o        = 16'h0000;
        mem_en_o           = 1'b0;
        mem_wr_o           = 1'b0;
        memory_address_o   = {ADDR_WIDTH{1'b0}};
        mem_data_in_o      = 16'h0000;
        wr_ack_o           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req_i) begin
                    mem_en_o         = 1'b1;
                    mem_wr_o         = 1'b1;
                    memory_address_o = {wr_addr_i[ADDR_WIDTH-1:1], 1'b0};
                    mem_data_in_o    = wr_data_i;
                    wr_ack_o         = 1'b1;
                end else begin
                    mem_en_o         = 1'b0;
                    mem_wr_o         = 1'b0;
                    memory_address_o = {ADDR_WIDTH{1'b0}};
                    mem_data_in_o    = 16'h0000;
                    wr_ack_o         = 1'b0;
                end
            end
            ST_FILL: begin
                fsm_busy_o         = 1'b1;
                mem_en_o           = 1'b1;
                mem_wr_o           = 1'b0;
                memory_address_o   = fill_base_q + word_off_s;
                fill_word_o        = cnt_q;
                fill_data_o        = memory_data_i;
                write_data_array_o = 1'b1;
                write_tag_array_o  = last_word_s;
            end
            default: begin
                fsm_busy_o = 1'b0;
            end
        endcase
    end

endmodule
